regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of each register.
REQ-002 SHALL have parameter NREG, default 32, register count; AW = clog2(NREG); NREG SHALL be a power of two, >= 4.
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports; higher port index has higher priority.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 we  in  NWR  per-port write enable.
REQ-008 wr_addr  in  NWR*AW  packed write addresses, port k at bits [k*AW +: AW].
REQ-009 wr_data  in  NWR*XLEN  packed write data.
REQ-010 rd_addr  in  NRD*AW  packed read addresses.
REQ-011 rd_data  out  NRD*XLEN  packed read data, combinational.
REQ-012 rd_busy  out  NRD  scoreboard busy bit of each read address.
REQ-013 alloc_valid / alloc_addr  in  1 / AW  mark destination register pending (issue stage).
REQ-014 clr_req  in  1  start sequential clear of all registers.
REQ-015 wr_ready  out  1  high when writes and allocs are accepted.
REQ-016 clr_done  out  1  one-cycle pulse at clear completion.
REQ-017 dbg_addr / dbg_data  in AW / out XLEN  debug read port, no forwarding; gp  out  XLEN  always register 3.

Function
REQ-018 Register 0 SHALL read 0 on every port; writes, allocs and busy to address 0 SHALL be ignored (rd_busy=0).
REQ-019 Write: on rising clk with we[k]=1, wr_ready=1, wr_addr[k]!=0, register wr_addr[k] SHALL take wr_data[k].
REQ-020 Same-cycle writes to one address from several ports: highest-index enabled port SHALL win.
REQ-021 Read: rd_data[j] SHALL equal stored register unless forwarding applies (REQ-033).
REQ-022 Scoreboard: busy[a] SHALL set on edge with alloc_valid=1, wr_ready=1, alloc_addr=a!=0; SHALL clear on edge with any accepted write to a.
REQ-023 Alloc and write to same address same cycle: busy SHALL end 1 (new producer wins); write data still stored.
REQ-024 rd_busy[j] SHALL reflect registered busy state (no same-cycle clear/set bypass).
REQ-025 FSM states IDLE, CLEAR. IDLE->CLEAR on clr_req=1; idx loads 1.
REQ-026 In CLEAR: each cycle register idx and busy[idx] SHALL be zeroed, idx increments; at idx=NREG-1 that cycle clears it, FSM->IDLE, clr_done pulses next cycle (exactly one cycle).
REQ-027 Clear latency SHALL be NREG-1 cycles from accepted clr_req to return to IDLE; wr_ready=0 throughout CLEAR, 1 in IDLE.
REQ-028 While wr_ready=0, we and alloc_valid SHALL be ignored (no state change); reads stay valid, returning partially cleared contents.
REQ-029 clr_req while in CLEAR SHALL be ignored (no restart).
REQ-030 clr_req in IDLE coinciding with writes: writes in that cycle SHALL be accepted, then clearing begins.

Reset
REQ-031 On rst=1 (asynchronous), all registers, busy bits SHALL become 0, FSM IDLE, idx 0, clr_done 0; wr_ready=1 after rst deasserts; rd_data, dbg_data, gp SHALL read 0 during reset.
REQ-032 rst during CLEAR SHALL abort clear; no clr_done pulse.

Configuration
REQ-033 Macro REGFILE_BYPASS_EN defined: rd_data[j] SHALL return wr_data of highest-index port with we=1, wr_ready=1, matching nonzero address in the same cycle; undefined: rd_data SHALL return stored value only (new data visible the cycle after the edge). dbg_data and gp SHALL never forward.

Verification
REQ-034 Reset, write x5=0x1234_5678 via port 0; next cycle rd_addr0=5 -> rd_data0=0x1234_5678, gp=0.
REQ-035 Same cycle we=2'b11, both addr 7, data 0xAAAA_0000 / 0x0000_BBBB -> x7=0x0000_BBBB; with REGFILE_BYPASS_EN, rd_addr=7 same cycle shows 0x0000_BBBB, without shows prior value.
REQ-036 alloc x9, next cycle rd_busy=1; write x9=0x55 -> rd_busy=0 next cycle; alloc and write x9 same cycle -> rd_busy stays 1, x9=0x55.
REQ-037 Fill x1..x31 nonzero, pulse clr_req -> wr_ready=0 for 31 cycles, clr_done one-cycle pulse, all reads 0; write attempted mid-clear has no effect.
REQ-038 Write x0=0xFFFF_FFFF and alloc x0 -> rd_data=0, rd_busy=0.
REQ-039 Assert rst at clear cycle 10 -> all regs 0, no clr_done, wr_ready=1 after deassert.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with pending-write scoreboard and sequential clear.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 alloc_valid,
  input  logic [AW-1:0]        alloc_addr,
  input  logic                 clr_req,
  output logic                 wr_ready,
  output logic                 clr_done,
  input  logic [AW-1:0]        dbg_addr,
  output logic [XLEN-1:0]      dbg_data,
  output logic [XLEN-1:0]      gp
);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q;
  logic [AW-1:0]     idx_q;
  logic              clr_done_q;
  logic [XLEN-1:0]   regs_q [NREG];
  logic [XLEN-1:0]   regs_d [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  assign wr_ready = (state_q == IDLE) && !rst;
  assign clr_done = clr_done_q;

  // Ascending port order lets the highest-index port win; alloc beats write.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ready) begin
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && wr_addr[k*AW +: AW] != '0) begin
          regs_d[wr_addr[k*AW +: AW]] = wr_data[k*XLEN +: XLEN];
          busy_d[wr_addr[k*AW +: AW]] = 1'b0;
        end
      end
      if (alloc_valid && alloc_addr != '0) begin
        busy_d[alloc_addr] = 1'b1;
      end
    end else if (state_q == CLEAR) begin
      regs_d[idx_q] = '0;
      busy_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= CLEAR;
            idx_q   <= AW'(1);
          end
        end
        CLEAR: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == AW'(NREG-1)) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            clr_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    logic [AW-1:0] ra;
    ra      = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int j = 0; j < NRD; j++) begin
      ra = rd_addr[j*AW +: AW];
      rd_data[j*XLEN +: XLEN] = regs_q[ra];
      rd_busy[j] = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NWR; k++) begin
        if (wr_ready && we[k] && ra != '0 &&
            wr_addr[k*AW +: AW] == ra) begin
          rd_data[j*XLEN +: XLEN] = wr_data[k*XLEN +: XLEN];
        end
      end
`else
      ra = ra;
`endif
    end
  end

  assign dbg_data = regs_q[dbg_addr];
  assign gp       = regs_q[3];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: writes, priority, scoreboard, clear, reset.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        we;
  logic [2*AW-1:0]   wr_addr;
  logic [2*XLEN-1:0] wr_data;
  logic [2*AW-1:0]   rd_addr;
  logic [2*XLEN-1:0] rd_data;
  logic [1:0]        rd_busy;
  logic              alloc_valid;
  logic [AW-1:0]     alloc_addr;
  logic              clr_req;
  logic              wr_ready;
  logic              clr_done;
  logic [AW-1:0]     dbg_addr;
  logic [XLEN-1:0]   dbg_data;
  logic [XLEN-1:0]   gp;

  int n_cmp = 0;
  int n_err = 0;

  regfile_mp dut (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .alloc_valid(alloc_valid),
    .alloc_addr(alloc_addr), .clr_req(clr_req),
    .wr_ready(wr_ready), .clr_done(clr_done),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .gp(gp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0;
    wr_addr = '0;
    wr_data = '0;
    alloc_valid = 1'b0;
    alloc_addr = '0;
    clr_req = 1'b0;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a,
                        input logic [XLEN-1:0] d);
    we[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    rd_addr = '0;
    dbg_addr = 5'd3;
    #12;
    set_wr(0, 5'd3, 32'hDEAD_BEEF);
    set_rd(0, 5'd3);
    #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rd: got %h want 0", rd_data[31:0]);
    end
    n_cmp++;
    if (gp !== 32'h0 || dbg_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_gp_dbg: got %h/%h want 0", gp, dbg_data);
    end
    tick();
    idle();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b1 || clr_done !== 1'b0 || rd_busy !== 2'b00) begin
      n_err++;
      $display("FAIL reset_ctl: got rdy=%b done=%b busy=%b want 1/0/00",
               wr_ready, clr_done, rd_busy);
    end
    n_cmp++;
    if (gp !== 32'h0) begin
      n_err++;
      $display("FAIL reset_x3: got %h want 0", gp);
    end
  endtask

  task automatic test_write();
    idle();
    set_wr(0, 5'd5, 32'h1234_5678);
    set_rd(0, 5'd5);
    dbg_addr = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    n_cmp++;
    if (rd_data[31:0] !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL wr_fwd: got %h want 12345678", rd_data[31:0]);
    end
`else
    n_cmp++;
    if (rd_data[31:0] !== 32'h0) begin
      n_err++;
      $display("FAIL wr_nofwd: got %h want 0", rd_data[31:0]);
    end
`endif
    n_cmp++;
    if (dbg_data !== 32'h0) begin
      n_err++;
      $display("FAIL dbg_nofwd: got %h want 0", dbg_data);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h1234_5678 || gp !== 32'h0) begin
      n_err++;
      $display("FAIL wr_x5: got %h gp %h want 12345678 gp 0",
               rd_data[31:0], gp);
    end
    n_cmp++;
    if (dbg_data !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL dbg_x5: got %h want 12345678", dbg_data);
    end
    set_wr(1, 5'd3, 32'hCAFE_F00D);
    #1;
    n_cmp++;
    if (gp !== 32'h0) begin
      n_err++;
      $display("FAIL gp_nofwd: got %h want 0", gp);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (gp !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL gp_x3: got %h want cafef00d", gp);
    end
  endtask

  task automatic test_priority();
    idle();
    set_wr(0, 5'd7, 32'hAAAA_0000);
    set_wr(1, 5'd7, 32'h0000_BBBB);
    set_rd(1, 5'd7);
    #1;
`ifdef REGFILE_BYPASS_EN
    n_cmp++;
    if (rd_data[63:32] !== 32'h0000_BBBB) begin
      n_err++;
      $display("FAIL prio_fwd: got %h want 0000bbbb", rd_data[63:32]);
    end
`else
    n_cmp++;
    if (rd_data[63:32] !== 32'h0) begin
      n_err++;
      $display("FAIL prio_nofwd: got %h want 0", rd_data[63:32]);
    end
`endif
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_data[63:32] !== 32'h0000_BBBB) begin
      n_err++;
      $display("FAIL prio_x7: got %h want 0000bbbb", rd_data[63:32]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    set_rd(0, 5'd9);
    alloc_valid = 1'b1;
    alloc_addr = 5'd9;
    #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL sb_nobypass_set: got %b want 0", rd_busy[0]);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL sb_alloc: got %b want 1", rd_busy[0]);
    end
    set_wr(1, 5'd9, 32'h55);
    #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL sb_nobypass_clr: got %b want 1", rd_busy[0]);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h55) begin
      n_err++;
      $display("FAIL sb_write: got busy %b data %h want 0 00000055",
               rd_busy[0], rd_data[31:0]);
    end
    set_wr(0, 5'd9, 32'h66);
    alloc_valid = 1'b1;
    alloc_addr = 5'd9;
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h66) begin
      n_err++;
      $display("FAIL sb_both: got busy %b data %h want 1 00000066",
               rd_busy[0], rd_data[31:0]);
    end
  endtask

  task automatic test_x0();
    idle();
    set_wr(0, 5'd0, 32'hFFFF_FFFF);
    set_wr(1, 5'd0, 32'hFFFF_FFFF);
    alloc_valid = 1'b1;
    alloc_addr = 5'd0;
    set_rd(0, 5'd0);
    set_rd(1, 5'd0);
    #1;
    n_cmp++;
    if (rd_data !== 64'h0) begin
      n_err++;
      $display("FAIL x0_same: got %h want 0", rd_data);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
      n_err++;
      $display("FAIL x0_after: got %h busy %b want 0 00",
               rd_data, rd_busy);
    end
  endtask

  task automatic test_clear();
    int cnt;
    int nz;
    idle();
    for (int i = 1; i < NREG; i += 2) begin
      idle();
      set_wr(0, AW'(i), 32'h1000_0000 + i);
      if (i + 1 < NREG) set_wr(1, AW'(i + 1), 32'h1000_0000 + i + 1);
      tick();
    end
    idle();
    alloc_valid = 1'b1;
    alloc_addr = 5'd4;
    tick();
    idle();
    set_rd(0, 5'd4);
    #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h1000_0004) begin
      n_err++;
      $display("FAIL clr_pre: got busy %b data %h want 1 10000004",
               rd_busy[0], rd_data[31:0]);
    end
    clr_req = 1'b1;
    set_wr(0, 5'd20, 32'h0000_ABCD);
    tick();
    idle();
    cnt = 0;
    while (wr_ready === 1'b0 && cnt < 40) begin
      cnt++;
      if (clr_done !== 1'b0) begin
        n_err++;
        $display("FAIL clr_early_done: cycle %0d got 1 want 0", cnt);
      end
      idle();
      if (cnt == 5) clr_req = 1'b1;
      if (cnt == 10) begin
        set_rd(0, 5'd20);
        set_rd(1, 5'd5);
        #1;
        n_cmp++;
        if (rd_data[31:0] !== 32'h0000_ABCD || rd_data[63:32] !== 32'h0) begin
          n_err++;
          $display("FAIL clr_partial: got %h/%h want 0000abcd/0",
                   rd_data[31:0], rd_data[63:32]);
        end
        set_wr(0, 5'd2, 32'h0BAD_0BAD);
        alloc_valid = 1'b1;
        alloc_addr = 5'd2;
      end
      tick();
    end
    n_cmp++;
    if (cnt !== 31 || clr_done !== 1'b1) begin
      n_err++;
      $display("FAIL clr_latency: got %0d cycles done=%b want 31 done=1",
               cnt, clr_done);
    end
    idle();
    tick();
    n_cmp++;
    if (clr_done !== 1'b0 || wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL clr_pulse: got done=%b rdy=%b want 0/1",
               clr_done, wr_ready);
    end
    nz = 0;
    for (int a = 0; a < NREG; a++) begin
      set_rd(0, AW'(a));
      dbg_addr = AW'(a);
      #1;
      if (rd_data[31:0] !== 32'h0 || dbg_data !== 32'h0 || rd_busy[0] !== 1'b0)
        nz++;
    end
    n_cmp++;
    if (nz !== 0) begin
      n_err++;
      $display("FAIL clr_all_zero: got %0d nonzero regs want 0", nz);
    end
  endtask

  task automatic test_reset_mid_clear();
    int dones;
    idle();
    set_wr(0, 5'd10, 32'h0000_0010);
    set_wr(1, 5'd25, 32'h0000_0025);
    tick();
    idle();
    set_wr(0, 5'd3, 32'h0000_0033);
    tick();
    idle();
    clr_req = 1'b1;
    tick();
    idle();
    for (int c = 0; c < 10; c++) tick();
    #2;
    rst = 1'b1;
    set_rd(0, 5'd25);
    #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h0 || gp !== 32'h0) begin
      n_err++;
      $display("FAIL rstclr_during: got %h gp %h want 0 0",
               rd_data[31:0], gp);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstclr_ready: got %b want 1", wr_ready);
    end
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (clr_done !== 1'b0 || wr_ready !== 1'b1) dones++;
      tick();
    end
    n_cmp++;
    if (dones !== 0) begin
      n_err++;
      $display("FAIL rstclr_nodone: got %0d bad cycles want 0", dones);
    end
    set_rd(0, 5'd25);
    set_rd(1, 5'd10);
    #1;
    n_cmp++;
    if (rd_data !== 64'h0) begin
      n_err++;
      $display("FAIL rstclr_regs: got %h want 0", rd_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write();
    test_priority();
    test_scoreboard();
    test_x0();
    test_clear();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
